// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Latency: n/a (types, constants and a pure address helper only).
// Backpressure: n/a.
package loader_pkg;

    // Loader FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    // Byte address of instruction number cnt relative to base.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [LEN_W-1:0] cnt);
        return base + {14'd0, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bundle of the loader's control, byte-stream and memory-write signals.
// Latency: n/a (wiring only).
// Backpressure: rx_ready throttles the byte source; the memory port has none.
// Modports:
//   master - the loader: takes start/rx_data/rx_valid, drives everything else.
//   slave  - the surrounding system: byte source, memory, CPU hold consumer.
interface instr_mem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit words.
// Latency: word/word_valid registered, valid in the cycle after the 4th byte.
// Backpressure: none; byte_valid must already be qualified by the handshake.
// Ports: clk/rst (sync, active-high), clr (restart packing), byte_valid/byte_data
// (accepted byte), word/word_valid (assembled word + 1-cycle pulse),
// last_byte (the next accepted byte completes a word).
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;
    logic        word_valid_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_q       <= '0;
            byte_cnt_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid && (byte_cnt_q == LAST_IDX);
            if (byte_valid) begin
                word_q     <= {word_q[23:0], byte_data};
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign last_byte  = (byte_cnt_q == LAST_IDX);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian words -> instruction memory.
// Latency: write strobe one cycle after a word's 4th byte; done two cycles after the last byte.
// Backpressure: rx_ready high only in LEN_HI/LEN_LO/DATA; memory writes never stall.
// Ports: clk, rst (sync, active-high); bus (master modport) carries start, the
// rx_* byte handshake, the im_* write port, cpu_hold, done and sticky error.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_loader_if.master bus
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic             error_q;

    logic             rx_ready;
    logic             accept;
    logic [LEN_W-1:0] len_full;
    logic             len_zero;
    logic             len_over;
    logic             last_word;

    logic             asm_clr;
    logic             asm_byte_valid;
    logic [31:0]      asm_word;
    logic             asm_word_valid;
    logic             asm_last_byte;

    // Everything visible outside is decoded from registered state.
    assign rx_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA);
    assign accept   = bus.rx_valid && rx_ready;

    // Full length as it will be once the low byte in flight is latched.
    assign len_full  = {len_q[15:8], bus.rx_data};
    assign len_zero  = (len_full == '0);
    assign len_over  = (len_full > MAX_LEN);
    // word_cnt_q only advances in the strobe cycle, so during byte collection
    // it still holds the index of the word being assembled.
    assign last_word = (word_cnt_q == len_q - 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_LEN_HI;
            ST_LEN_HI: if (accept)    state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_zero)      state_d = ST_DONE;
                    else if (len_over) state_d = ST_IDLE;
                    else               state_d = ST_DATA;
                end
            end
            ST_DATA:   if (accept && asm_last_byte && last_word) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.start) error_q <= 1'b0;
            if (state_q == ST_LEN_HI && accept) len_q[15:8] <= bus.rx_data;
            if (state_q == ST_LEN_LO && accept) begin
                len_q[7:0] <= bus.rx_data;
                if (!len_zero && len_over) error_q <= 1'b1;
            end
            if (asm_clr)             word_cnt_q <= '0;
            else if (asm_word_valid) word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign asm_clr        = (state_q == ST_LEN_LO) && (state_d == ST_DATA);
    assign asm_byte_valid = accept && (state_q == ST_DATA);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_valid (asm_byte_valid),
        .byte_data  (bus.rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .last_byte  (asm_last_byte)
    );

    assign bus.rx_ready = rx_ready;
    assign bus.cpu_hold = rx_ready || (state_q == ST_FLUSH);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.error    = error_q;
    assign bus.im_we    = asm_word_valid;
    assign bus.im_wdata = asm_word_valid ? asm_word : 32'd0;
    assign bus.im_addr  = asm_word_valid ? word_byte_addr(BASE_ADDR, word_cnt_q) : 32'd0;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: cycle table plus multi-cycle sequences.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_loader_if bus ();

    instr_mem_loader #(
        .MAX_WORDS (256),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hold;
        logic        done;
        logic        err;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_wide = 0;
    int          done_cnt = 0;
    logic        prev_we = 1'b0;

    function automatic logic [68:0] outs();
        return {bus.rx_ready, bus.im_we, bus.im_addr, bus.im_wdata,
                bus.cpu_hold, bus.done, bus.error};
    endfunction

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic v, input logic [7:0] d);
        bus.start    = st;
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        if (bus.im_we === 1'b1) begin
            cap_addr.push_back(bus.im_addr);
            cap_data.push_back(bus.im_wdata);
            if (prev_we) we_wide++;
        end
        if (bus.done === 1'b1) done_cnt++;
        prev_we = bus.im_we;
    endtask

    task automatic add(input logic st, input logic v, input logic [7:0] d,
                       input logic rdy, input logic we, input logic [31:0] a,
                       input logic [31:0] w, input logic h, input logic dn, input logic e);
        vec_t x;
        x.st = st; x.vld = v; x.dat = d; x.rdy = rdy; x.we = we; x.addr = a;
        x.wdata = w; x.hold = h; x.done = dn; x.err = e;
        vq.push_back(x);
    endtask

    task automatic clear_caps();
        cap_addr.delete();
        cap_data.delete();
        we_wide  = 0;
        done_cnt = 0;
    endtask

    initial begin
        bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

        // Reset state
        step(0, 1, 8'hFF);
        step(0, 1, 8'hFF);
        chk("reset", outs(), 69'd0);
        rst = 1'b0;

        // Two-word load, back to back
        add(1,0,8'h00, 1,0,32'h0,32'h0,         1,0,0); // LEN_HI
        add(0,1,8'h00, 1,0,32'h0,32'h0,         1,0,0); // LEN_LO
        add(0,1,8'h02, 1,0,32'h0,32'h0,         1,0,0); // DATA
        add(0,1,8'h20, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h08, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h00, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h05, 1,1,32'h0,32'h20080005,  1,0,0); // word 0 strobe
        add(0,1,8'hAC, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h01, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h00, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h04, 0,1,32'h4,32'hAC010004,  1,0,0); // FLUSH
        add(0,0,8'h00, 0,0,32'h0,32'h0,         0,1,0); // DONE
        add(0,0,8'h00, 0,0,32'h0,32'h0,         0,0,0); // IDLE
        // Empty load
        add(1,0,8'h00, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h00, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h00, 0,0,32'h0,32'h0,         0,1,0); // DONE straight away
        add(0,0,8'h00, 0,0,32'h0,32'h0,         0,0,0);
        // Oversize length 0x0101
        add(1,0,8'h00, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h01, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h01, 0,0,32'h0,32'h0,         0,0,1); // IDLE, error
        add(0,1,8'h55, 0,0,32'h0,32'h0,         0,0,1); // byte in IDLE ignored
        add(1,0,8'h00, 1,0,32'h0,32'h0,         1,0,0); // start clears error
        // One-word load with start pulsed mid-DATA
        add(0,1,8'h00, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h01, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h12, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h34, 1,0,32'h0,32'h0,         1,0,0);
        add(1,1,8'h56, 1,0,32'h0,32'h0,         1,0,0);
        add(0,1,8'h78, 0,1,32'h0,32'h12345678,  1,0,0);
        add(0,0,8'h00, 0,0,32'h0,32'h0,         0,1,0);
        add(0,0,8'h00, 0,0,32'h0,32'h0,         0,0,0);

        foreach (vq[i]) begin
            step(vq[i].st, vq[i].vld, vq[i].dat);
            chk($sformatf("vec%0d", i), outs(),
                {vq[i].rdy, vq[i].we, vq[i].addr, vq[i].wdata,
                 vq[i].hold, vq[i].done, vq[i].err});
        end

        // Throttled source: valid one cycle in three
        begin
            logic [7:0] s [10];
            s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
            clear_caps();
            step(1, 0, 8'h00);
            foreach (s[i]) begin
                step(0, 1, s[i]);
                step(0, 0, 8'h00);
                step(0, 0, 8'h00);
            end
            chk("thr_nwr",   69'(cap_addr.size()), 69'd2);
            if (cap_addr.size() == 2) begin
                chk("thr_a0", 69'(cap_addr[0]), 69'h0);
                chk("thr_d0", 69'(cap_data[0]), 69'h20080005);
                chk("thr_a1", 69'(cap_addr[1]), 69'h4);
                chk("thr_d1", 69'(cap_data[1]), 69'hAC010004);
            end
            chk("thr_wide",  69'(we_wide), 69'd0);
            chk("thr_done",  69'(done_cnt), 69'd1);
            chk("thr_idle",  outs(), 69'd0);
        end

        // Reset in the middle of a three-word load
        clear_caps();
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h03);
        step(0, 1, 8'h11);
        step(0, 1, 8'h22);
        step(0, 1, 8'h33);
        step(0, 1, 8'h44);
        rst = 1'b1;
        step(0, 1, 8'h55);
        chk("rst_mid", outs(), 69'd0);
        rst = 1'b0;
        chk("rst_pre_wr", 69'(cap_data.size() == 1 ? cap_data[0] : 32'hDEAD_BEEF),
            69'h11223344);
        clear_caps();
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h12);
        step(0, 1, 8'h34);
        step(0, 1, 8'h56);
        step(0, 1, 8'h78);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("rst_nwr", 69'(cap_addr.size()), 69'd1);
        if (cap_addr.size() == 1) begin
            chk("rst_a0", 69'(cap_addr[0]), 69'h0);
            chk("rst_d0", 69'(cap_data[0]), 69'h12345678);
        end
        chk("rst_done", 69'(done_cnt), 69'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader for the single-cycle MIPS datapath. It accepts a length-prefixed byte stream over a valid/ready handshake and packs it big-endian into 32-bit instructions. It writes those instructions through the instruction memory's write port, starting at `BASE_ADDR`. It holds the CPU (`cpu_hold`) for the whole load, so the PC register and the instruction memory read side never see a partially loaded program.

## Interface
- `MAX_WORDS`, 256: instruction memory depth in words; must be ≤ 65535.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first instruction written; word-aligned.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a load; sampled only in IDLE.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction memory write strobe, one cycle per word.
- `im_addr`  out  32  byte address of the write.
- `im_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  datapath stall/reset request while loading.
- `done`  out  1  one-cycle pulse; load completed.
- `error`  out  1  sticky; length exceeded `MAX_WORDS`.

## Operation
- A byte transfers on any cycle with `rx_valid && rx_ready`. Bytes offered while `rx_ready=0` are ignored, not buffered.
- Stream format: `LEN[15:8]`, `LEN[7:0]`, then LEN words. Each word is 4 bytes, MSB first.
- States: IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE.
- **IDLE.** `rx_ready=0`, `cpu_hold=0`. When `start=1`: go to LEN_HI and clear `error`.
- **LEN_HI.** On transfer, latch `len[15:8]` and go to LEN_LO.
- **LEN_LO.** On transfer, latch `len[7:0]`, then:
  - len=0: go to DONE; no writes.
  - len>`MAX_WORDS`: set `error=1` and go to IDLE; no writes.
  - otherwise: clear `byte_cnt` and `word_cnt`, go to DATA.
- **DATA.** Each transfer shifts the byte into the word: `word = {word[23:0], rx_data}`. `byte_cnt` (2 bits) increments.
  - On the 4th byte: next cycle `im_we=1`, `im_wdata` = assembled word, `im_addr = BASE_ADDR + {word_cnt,2'b00}`. `word_cnt` then increments.
  - If that was word len-1, go to FLUSH. Otherwise stay in DATA with `rx_ready` still high.
- **FLUSH.** The final `im_we` cycle; `rx_ready=0`. Next state DONE.
- **DONE.** `done=1`, `cpu_hold=0`, `rx_ready=0`. Next state IDLE.
- `cpu_hold=1` exactly in LEN_HI, LEN_LO, DATA, FLUSH. `rx_ready=1` exactly in LEN_HI, LEN_LO, DATA.
- `start` is ignored outside IDLE. `error` holds until the next accepted `start` or `rst`.
- Memory has no backpressure: a write is accepted in its strobe cycle.

## Timing
- All outputs are decoded from registered state or counters. There is no combinational path from inputs to outputs.
- Byte accepted at edge k: if it is the 4th byte of a word, `im_we` is high during cycle k+1 only.
- Final byte at edge k: FLUSH with `im_we` in cycle k+1, DONE/`done` in cycle k+2, IDLE from k+3. `cpu_hold` falls at k+2.
- len=0: LEN_LO accepted at edge k, then `done` in cycle k+1.
- Throughput: 1 byte/cycle sustained; gaps in `rx_valid` only stretch the load.
- Reset values: state IDLE, all counters 0, `rx_ready=0`, `im_we=0`, `im_addr=0`, `im_wdata=0`, `cpu_hold=0`, `done=0`, `error=0`.
- `rst` mid-load: all of the above in the cycle after the edge. Partially written memory is left as is.
- `im_addr` and `im_wdata` are 0 when `im_we=0`.

## Structure
- Shared package `loader_pkg`:
  - 3-bit state encoding: IDLE=0, LEN_HI=1, LEN_LO=2, DATA=3, FLUSH=4, DONE=5.
  - `BYTES_PER_WORD=4`.
  - Length-field width 16.
- Sub-module `word_assembler`:
  - byte shift register plus 2-bit byte counter;
  - outputs `word` and a `word_valid` pulse;
  - cleared by `rst` and on entering DATA.
- The FSM, word counter, address generation and error flag stay in `instr_mem_loader`.

## Test plan
- **Two-word load.** Reset, `start`, stream 00 02 20 08 00 05 AC 01 00 04 back-to-back → writes 0x00000000←0x20080005 and 0x00000004←0xAC010004. `done` pulses 2 cycles after the last byte; `cpu_hold` high from the cycle after `start` until `done`.
- **Empty load.** `start`, 00 00 → no `im_we`; `done` the cycle after the second byte; `error=0`.
- **Oversize length.** `MAX_WORDS=256`, stream 01 01 → `error=1`, no `im_we`, back in IDLE with `rx_ready=0`. The next `start` clears `error`.
- **Throttled source.** Same stream as the two-word load with `rx_valid` high one cycle in three → identical writes and addresses; each `im_we` one cycle wide.
- **Reset mid-load.** `rst` after 6 bytes of a 3-word load → all outputs 0 the next cycle. A new `start` plus 1-word stream 00 01 12 34 56 78 → 0x00000000←0x12345678.
- **Ignored inputs.** `rx_valid` with data in IDLE → no state change; `start` pulsed during DATA → no restart, load completes normally.
